// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer: load scoreboard, RAW/WAW/EX-busy stalls and post-redirect flush bubbles.
// Optional macro WB_BYPASS_EN lets a same-cycle writeback clear unblock a stalled instruction.
module id_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
    input  logic                      id_MemRead_i,
    input  logic                      ex_ready_i,
    input  logic                      ex_redirect_i,
    input  logic                      wb_load_done_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
    output logic                      pc_stall_o,
    output logic                      if_id_stall_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_flush_o,
    output logic                      issue_o,
    output logic [NUM_REGS-1:0]       pending_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t              state_reg;
    logic [2:0]          cnt_reg;
    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;

    logic pend_rs1, pend_rs2, pend_rd;
    logic raw_hz, waw_hz, hz;
    logic flush_active;
    logic issue;
    logic set_en;

`ifdef WB_BYPASS_EN
    // A load completing this cycle no longer blocks: the register file writes through.
    assign pend_rs1 = pending_reg[id_rs1_addr_i] & ~(wb_load_done_i && (wb_rd_addr_i == id_rs1_addr_i));
    assign pend_rs2 = pending_reg[id_rs2_addr_i] & ~(wb_load_done_i && (wb_rd_addr_i == id_rs2_addr_i));
    assign pend_rd  = pending_reg[id_rd_addr_i]  & ~(wb_load_done_i && (wb_rd_addr_i == id_rd_addr_i));
`else
    assign pend_rs1 = pending_reg[id_rs1_addr_i];
    assign pend_rs2 = pending_reg[id_rs2_addr_i];
    assign pend_rd  = pending_reg[id_rd_addr_i];
`endif

    assign raw_hz = id_valid_i & ((id_rs1_used_i & pend_rs1) | (id_rs2_used_i & pend_rs2));
    assign waw_hz = id_valid_i & id_MemRead_i & pend_rd & (id_rd_addr_i != '0);
    assign hz     = raw_hz | waw_hz | (id_valid_i & ~ex_ready_i);

    assign flush_active = ex_redirect_i | (state_reg == ST_FLUSH);

    // Outputs are gated by rst_n so they fall to zero as soon as reset asserts.
    always_comb begin
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        issue         = 1'b0;
        if (rst_n) begin
            if (flush_active) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (hz) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = ex_ready_i;
            end else begin
                issue = id_valid_i;
            end
        end
    end

    assign issue_o = issue;
    assign set_en  = issue & id_MemRead_i & (id_rd_addr_i != '0);

    // Set beats clear on the same register: the issuing load is younger than the one retiring.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                assign pending_next[gi] =
                    (set_en && (id_rd_addr_i == REG_ADDR_WIDTH'(gi))) |
                    (pending_reg[gi] & ~(wb_load_done_i && (wb_rd_addr_i == REG_ADDR_WIDTH'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending_o = pending_reg;
    assign busy_o    = |pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (ex_redirect_i) begin
                        state_reg <= ST_FLUSH;
                        cnt_reg   <= FLUSH_RELOAD;
                    end else if (hz) begin
                        state_reg <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (ex_redirect_i) begin
                        state_reg <= ST_FLUSH;
                        cnt_reg   <= FLUSH_RELOAD;
                    end else if (!hz) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (ex_redirect_i) begin
                        cnt_reg <= FLUSH_RELOAD;
                    end else if (cnt_reg == 3'd0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expectations queued per step, popped and checked at the falling edge.
module tb_id_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_MemRead_i;
    logic        ex_ready_i;
    logic        ex_redirect_i;
    logic        wb_load_done_i;
    logic [4:0]  wb_rd_addr_i;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        issue_o;
    logic [31:0] pending_o;
    logic        busy_o;

    id_hazard_ctrl #(
        .REG_ADDR_WIDTH(5),
        .NUM_REGS      (32),
        .FLUSH_CYCLES  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_MemRead_i  (id_MemRead_i),
        .ex_ready_i    (ex_ready_i),
        .ex_redirect_i (ex_redirect_i),
        .wb_load_done_i(wb_load_done_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .pc_stall_o    (pc_stall_o),
        .if_id_stall_o (if_id_stall_o),
        .if_id_flush_o (if_id_flush_o),
        .id_ex_flush_o (id_ex_flush_o),
        .issue_o       (issue_o),
        .pending_o     (pending_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, issue}
    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_ISSUE = 5'b00001;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_HOLD  = 5'b11000;
    localparam logic [4:0] C_FLUSH = 5'b00110;

    typedef struct {
        string       tag;
        logic [4:0]  ctl;
        logic [31:0] pend;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic rdy, input logic redir,
                       input logic wbd, input logic [4:0] wbrd);
        id_valid_i     = v;
        id_rs1_addr_i  = rs1;
        id_rs1_used_i  = u1;
        id_rs2_addr_i  = rs2;
        id_rs2_used_i  = u2;
        id_rd_addr_i   = rd;
        id_MemRead_i   = mr;
        ex_ready_i     = rdy;
        ex_redirect_i  = redir;
        wb_load_done_i = wbd;
        wb_rd_addr_i   = wbrd;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic compare_out();
        exp_t       e;
        logic [4:0] got;
        n_cmp++;
        assert (q.size() > 0) else begin
            n_err++;
            $error("FAIL queue_empty observed=0 expected=1");
        end
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, issue_o};
            $display("t=%0t step %s ctl=%b pend=%h busy=%b", $time, e.tag, got, pending_o, busy_o);
            n_cmp++;
            assert (got === e.ctl) else begin
                n_err++;
                $error("FAIL %s_ctl observed=%b expected=%b", e.tag, got, e.ctl);
            end
            n_cmp++;
            assert (pending_o === e.pend) else begin
                n_err++;
                $error("FAIL %s_pending observed=%h expected=%h", e.tag, pending_o, e.pend);
            end
            n_cmp++;
            assert (busy_o === (|e.pend)) else begin
                n_err++;
                $error("FAIL %s_busy observed=%b expected=%b", e.tag, busy_o, |e.pend);
            end
        end
    endtask

    // Inputs are already driven; queue expectation, check at negedge, return just after next posedge.
    task automatic step(input string tag, input logic [4:0] ctl, input logic [31:0] pend);
        exp_t e;
        e.tag  = tag;
        e.ctl  = ctl;
        e.pend = pend;
        q.push_back(e);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("reset", C_IDLE, 32'h0);
        rst_n = 1'b1;

        // lw x5 then add x6,x5,x1
        drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 5'd0);
        step("lw_x5", C_ISSUE, 32'h0);
        drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 1, 0, 0, 5'd0);
        step("raw_stall0", C_STALL, 32'h20);
        step("raw_stall1", C_STALL, 32'h20);
        drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 1, 0, 1, 5'd5);
`ifdef WB_BYPASS_EN
        step("raw_wb_bypass", C_ISSUE, 32'h20);
        idle();
        step("raw_after", C_IDLE, 32'h0);
`else
        step("raw_wb", C_STALL, 32'h20);
        drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 1, 0, 0, 5'd0);
        step("raw_issue", C_ISSUE, 32'h0);
`endif

        // lw x0 never marks anything
        drv(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 5'd0);
        step("lw_x0", C_ISSUE, 32'h0);
        drv(1, 5'd0, 1, 5'd0, 1, 5'd8, 0, 1, 0, 0, 5'd0);
        step("use_x0", C_ISSUE, 32'h0);

        // redirect pulse: three flush cycles
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 1, 0, 5'd0);
        step("redir_pulse", C_FLUSH, 32'h0);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 0, 0, 5'd0);
        step("flush1", C_FLUSH, 32'h0);
        step("flush2", C_FLUSH, 32'h0);
        step("flush_done", C_ISSUE, 32'h0);

        // second redirect on the last flush cycle extends the window
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 1, 0, 5'd0);
        step("redir_a", C_FLUSH, 32'h0);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 0, 0, 5'd0);
        step("ext_f1", C_FLUSH, 32'h0);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 1, 0, 5'd0);
        step("redir_b", C_FLUSH, 32'h0);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 0, 0, 5'd0);
        step("ext_f2", C_FLUSH, 32'h0);
        step("ext_f3", C_FLUSH, 32'h0);
        step("ext_done", C_ISSUE, 32'h0);

        // lw x7 issuing while x7 retires: set wins
        drv(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1, 5'd7);
        step("lw_x7_wb_x7", C_ISSUE, 32'h0);
        idle();
        step("x7_set", C_IDLE, 32'h80);
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 5'd7);
        step("x7_clear", C_IDLE, 32'h80);
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 5'd3);
        step("x3_noop_clear", C_IDLE, 32'h0);
        idle();
        step("sb_empty", C_IDLE, 32'h0);

        // WAW: lw x9 then lw x9
        drv(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 5'd0);
        step("lw_x9_a", C_ISSUE, 32'h0);
        drv(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 5'd0);
        step("waw_stall", C_STALL, 32'h200);
        drv(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 0, 1, 5'd9);
`ifdef WB_BYPASS_EN
        step("waw_wb_bypass", C_ISSUE, 32'h200);
`else
        step("waw_wb", C_STALL, 32'h200);
        drv(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 5'd0);
        step("waw_issue", C_ISSUE, 32'h0);
`endif
        idle();
        step("x9_again", C_IDLE, 32'h200);
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 5'd9);
        step("x9_clear", C_IDLE, 32'h200);

        // EX not ready, no hazard: hold ID2EX without a bubble
        drv(1, 5'd1, 1, 5'd2, 1, 5'd4, 0, 0, 0, 0, 5'd0);
        step("ex_busy_hold", C_HOLD, 32'h0);
        drv(0, 5'd1, 1, 5'd2, 1, 5'd4, 0, 0, 0, 0, 5'd0);
        step("ex_busy_novalid", C_IDLE, 32'h0);
        drv(1, 5'd1, 1, 5'd2, 1, 5'd4, 0, 1, 0, 0, 5'd0);
        step("ex_ready_issue", C_ISSUE, 32'h0);

        // reset in the middle of a stall with x5 and x7 pending
        drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 5'd0);
        step("lw_x5_b", C_ISSUE, 32'h0);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 5'd0);
        step("lw_x7_b", C_ISSUE, 32'h20);
        drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 0, 1, 0, 0, 5'd0);
        step("stall_a0", C_STALL, 32'hA0);
        rst_n = 1'b0;
        step("rst_in_stall", C_IDLE, 32'h0);
        rst_n = 1'b1;
        step("after_rst", C_ISSUE, 32'h0);

        // reset in the middle of a flush
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 1, 0, 5'd0);
        step("redir_c", C_FLUSH, 32'h0);
        drv(1, 5'd1, 1, 5'd0, 0, 5'd3, 0, 1, 0, 0, 5'd0);
        rst_n = 1'b0;
        step("rst_in_flush", C_IDLE, 32'h0);
        rst_n = 1'b1;
        step("run_after_rst", C_ISSUE, 32'h0);

        idle();
        step("final", C_IDLE, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Pipeline sequencing controller for the decode stage. It keeps a scoreboard of registers with loads in flight and stalls IF/ID while a decoded instruction depends on one of them. It also sequences flush bubbles after a taken branch or jump resolved in EX. It sits beside the decode stage and drives the stall/flush enables of the PC, IF2ID and ID2EX pipeline registers.

Parameters:
REG_ADDR_WIDTH, 5, register address width
NUM_REGS, 32, number of architectural registers (2**REG_ADDR_WIDTH)
FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (1..7)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  IF2ID holds a valid instruction
id_rs1_addr_i  in  REG_ADDR_WIDTH  decoded rs1
id_rs2_addr_i  in  REG_ADDR_WIDTH  decoded rs2
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_addr_i  in  REG_ADDR_WIDTH  decoded rd
id_MemRead_i  in  1  instruction is a load
ex_ready_i  in  1  EX accepts an ID2EX transfer this cycle
ex_redirect_i  in  1  branch taken or jump resolved in EX
wb_load_done_i  in  1  load result written back this cycle
wb_rd_addr_i  in  REG_ADDR_WIDTH  destination of completing load
pc_stall_o  out  1  hold PC
if_id_stall_o  out  1  hold IF2ID
if_id_flush_o  out  1  clear IF2ID valid
id_ex_flush_o  out  1  insert bubble into ID2EX
issue_o  out  1  instruction transfers ID to EX this cycle
pending_o  out  NUM_REGS  scoreboard, bit n = load to xn in flight
busy_o  out  1  |pending_o

Behaviour:
- Reset (async, rst_n=0): pending_o=0; FSM=RUN; flush counter=0; all stall/flush outputs 0; issue_o 0.
- Scoreboard: register file, one bit per register. Bit 0 is hardwired 0.
  - Set on issue_o & id_MemRead_i & id_rd_addr_i!=0, at the next edge.
  - Clear on wb_load_done_i at wb_rd_addr_i, at the next edge.
  - Same register set and cleared in one cycle: set wins, because the new load is younger.
  - Clearing a bit that is already 0 is a no-op.
- raw_hz, combinational: id_valid_i & ((id_rs1_used_i & pending[rs1]) | (id_rs2_used_i & pending[rs2])).
- waw_hz, combinational: id_valid_i & id_MemRead_i & pending[rd] & rd!=0.
- hz = raw_hz | waw_hz | (id_valid_i & ~ex_ready_i).
- FSM states and transitions:
  - RUN: if ex_redirect_i, go to FLUSH with cnt=FLUSH_CYCLES-1. Otherwise if hz, go to STALL. Otherwise stay in RUN.
  - STALL: ex_redirect_i goes to FLUSH (redirect has priority). Otherwise if hz clears, go to RUN. Otherwise stay in STALL.
  - FLUSH: when cnt==0, go to RUN. Otherwise decrement cnt. A new ex_redirect_i during FLUSH reloads cnt=FLUSH_CYCLES-1.
- Outputs (combinational from state and inputs, zero added latency):
  - redirect this cycle, or state FLUSH: if_id_flush_o=1, id_ex_flush_o=1, pc_stall_o=0, if_id_stall_o=0, issue_o=0.
  - Otherwise, if hz: pc_stall_o=if_id_stall_o=1, and id_ex_flush_o=~ex_ready_i ? 0 : 1. When EX is full, ID2EX is held rather than bubbled.
  - Otherwise: issue_o=id_valid_i; all stall/flush outputs 0.
- Stall and flush are never asserted together.
- Stall-to-issue latency: issue_o rises in the same cycle the blocking bit clears (with WB_BYPASS_EN), or one cycle later (without).
- A reset asserted mid-stall or mid-flush returns the block to RUN immediately and empties the scoreboard.

Optional Feature:
WB_BYPASS_EN
- Defined: pending bits are masked by the same-cycle clear (wb_load_done_i & wb_rd_addr_i==src) when computing raw_hz/waw_hz. The register file write-through supplies the data.
- Undefined: hazard uses registered bits only, which costs one extra stall cycle per load-use.

Test Plan:
- Issue lw x5 (MemRead, rd=5), then add x6,x5,x1 -> pending_o[5]=1 after issue; add is stalled (pc_stall_o=if_id_stall_o=id_ex_flush_o=1) until wb_load_done_i with rd=5; issue_o follows at bypass-dependent latency.
- lw x0 -> pending_o stays 0; a dependent instruction reading x0 issues with no stall.
- ex_redirect_i pulse with FLUSH_CYCLES=2 -> if_id_flush_o=id_ex_flush_o=1 for exactly 3 cycles (pulse cycle plus 2); no issue_o during them; second redirect mid-flush extends the window.
- Same cycle: issue lw x7 while wb_load_done_i for x7 -> pending_o[7]=1 afterwards.
- lw x9, then lw x9 while first in flight -> waw stall until clear; ex_ready_i=0 with no hazard -> stall with id_ex_flush_o=0.
- rst_n low during STALL with pending_o=32'h0000_00A0 -> outputs 0 and pending_o=0 asynchronously; RUN after release.
